// File: rtl/mac_sm_acc_pipe.sv
// mac_sm_acc_pipe: P-lane unsigned x sign-magnitude MAC, pipelined adder tree and framed accumulator (in: clk, rst_n, i_valid/i_first/i_last, i_activation, i_weight; out: o_valid, o_result, o_sat)
module mac_sm_acc_pipe #(
  parameter int ACT_W    = 4,
  parameter int WT_W     = 4,
  parameter int P        = 8,
  parameter int ACC_W    = 16,
  parameter int SATURATE = 1
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic               i_first,
  input  logic               i_last,
  input  logic [ACT_W*P-1:0] i_activation,
  input  logic [WT_W*P-1:0]  i_weight,
  output logic               o_valid,
  output logic [ACC_W-1:0]   o_result,
  output logic               o_sat
);
  localparam int LOG2P = $clog2(P);
  localparam int PW = ACT_W + WT_W;
  localparam int SW = PW + LOG2P;
  localparam logic signed [ACC_W-1:0] MAXV = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] MINV = {1'b1, {(ACC_W-1){1'b0}}};
  typedef enum logic {IDLE, ACCUM} state_t;
  function automatic logic signed [PW-1:0] lane_prod(input logic [ACT_W-1:0] a, input logic [WT_W-1:0] w);
    logic [PW-1:0] m;
    m = PW'(a) * PW'(w[WT_W-2:0]);
    return w[WT_W-1] ? -m : m;
  endfunction
  genvar l;
  for (l = 0; l <= LOG2P; l++) begin : lv
    logic signed [PW+l-1:0] s [P>>l];
    if (l == 0) begin : g
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int k = 0; k < P; k++) s[k] <= '0;
        else for (int k = 0; k < P; k++) s[k] <= lane_prod(i_activation[k*ACT_W +: ACT_W], i_weight[k*WT_W +: WT_W]);
    end else begin : g
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) for (int k = 0; k < (P>>l); k++) s[k] <= '0;
        else for (int k = 0; k < (P>>l); k++) s[k] <= (PW+l)'(lv[l-1].s[2*k]) + (PW+l)'(lv[l-1].s[2*k+1]);
    end
  end
  // beat tags ride alongside the tree; first/last are only meaningful on valid beats
  logic [LOG2P:0] tv, tf, tl;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      tv <= '0;
      tf <= '0;
      tl <= '0;
    end else begin
      tv <= {tv[LOG2P-1:0], i_valid};
      tf <= {tf[LOG2P-1:0], i_valid & i_first};
      tl <= {tl[LOG2P-1:0], i_valid & i_last};
    end
  logic signed [SW-1:0]    bs;
  logic signed [ACC_W-1:0] acc, nxt;
  logic signed [ACC_W:0]   ext;
  logic                    ovf, sat, done;
  state_t                  state;
  assign bs  = lv[LOG2P].s[0];
  assign ext = (ACC_W+1)'(acc) + (ACC_W+1)'(bs);
  assign ovf = ext[ACC_W] ^ ext[ACC_W-1];
  assign nxt = (ovf && SATURATE != 0) ? (ext[ACC_W] ? MINV : MAXV) : ext[ACC_W-1:0];
  // done marks a completed frame; the output register picks up acc one edge later
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      acc      <= '0;
      sat      <= 1'b0;
      done     <= 1'b0;
      o_valid  <= 1'b0;
      o_result <= '0;
      o_sat    <= 1'b0;
    end else begin
      done <= tl[LOG2P] && (tf[LOG2P] || state == ACCUM);
      if (tf[LOG2P]) begin
        acc   <= ACC_W'(bs);
        sat   <= 1'b0;
        state <= tl[LOG2P] ? IDLE : ACCUM;
      end else if (tv[LOG2P] && state == ACCUM) begin
        acc   <= nxt;
        sat   <= sat | ovf;
        state <= tl[LOG2P] ? IDLE : ACCUM;
      end
      o_valid <= done;
      if (done) begin
        o_result <= acc;
        o_sat    <= sat;
      end
    end
endmodule

// File: tb/tb_mac_sm_acc_pipe.sv
// tb_mac_sm_acc_pipe: scoreboard bench for three mac_sm_acc_pipe configurations (16-bit sat, 12-bit sat, 12-bit wrap)
module tb_mac_sm_acc_pipe;
  localparam int P = 8;
  typedef struct {int r; logic s; int c;} exp_t;
  typedef struct {logic [31:0] a; logic [31:0] w; int r;} vec_t;
  logic clk = 0, rst_n = 0, iv = 0, ifs = 0, il = 0;
  logic [31:0] ia = '0, iw = '0;
  logic ov[3], os[3];
  logic [15:0] r0;
  logic [11:0] r1, r2;
  int res[3];
  exp_t q[3][$];
  int wd[3] = '{16, 12, 12};
  bit satv[3] = '{1, 1, 0};
  int macc[3], hold[3];
  bit msat[3], mst[3];
  int cyc = 0, total = 0, bad = 0;
  vec_t tbl[7];
  mac_sm_acc_pipe u0 (.clk(clk), .rst_n(rst_n), .i_valid(iv), .i_first(ifs), .i_last(il),
    .i_activation(ia), .i_weight(iw), .o_valid(ov[0]), .o_result(r0), .o_sat(os[0]));
  mac_sm_acc_pipe #(.ACC_W(12)) u1 (.clk(clk), .rst_n(rst_n), .i_valid(iv), .i_first(ifs), .i_last(il),
    .i_activation(ia), .i_weight(iw), .o_valid(ov[1]), .o_result(r1), .o_sat(os[1]));
  mac_sm_acc_pipe #(.ACC_W(12), .SATURATE(0)) u2 (.clk(clk), .rst_n(rst_n), .i_valid(iv), .i_first(ifs), .i_last(il),
    .i_activation(ia), .i_weight(iw), .o_valid(ov[2]), .o_result(r2), .o_sat(os[2]));
  always_comb begin
    res[0] = int'($signed(r0));
    res[1] = int'($signed(r1));
    res[2] = int'($signed(r2));
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  function automatic int dot(input logic [31:0] a, input logic [31:0] w);
    int s;
    logic [3:0] x, y;
    s = 0;
    for (int k = 0; k < P; k++) begin
      x = a[k*4 +: 4];
      y = w[k*4 +: 4];
      s += (y[3] ? -1 : 1) * int'(x) * int'(y[2:0]);
    end
    return s;
  endfunction
  task automatic chk(input string n, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0d required %0d", n, act, req);
    end
  endtask
  always @(posedge clk) begin : mon
    exp_t e;
    #1;
    if (rst_n) for (int d = 0; d < 3; d++) begin
      if (ov[d]) begin
        if (q[d].size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_o_valid dut%0d: got o_valid=1 required 0 at cycle %0d", d, cyc);
        end else begin
          e = q[d].pop_front();
          chk($sformatf("result dut%0d", d), res[d], e.r);
          chk($sformatf("sat dut%0d", d), int'(os[d]), int'(e.s));
          chk($sformatf("latency dut%0d", d), cyc, e.c);
          hold[d] = e.r;
        end
      end else chk($sformatf("hold dut%0d", d), res[d], hold[d]);
    end
  end
  // drives one cycle of inputs and advances the frame model of each configuration
  task automatic beat(input bit v, input bit f, input bit l, input logic [31:0] a, input logic [31:0] w,
                      input bit use_ovr = 0, input int ovr = 0);
    int smp, s;
    longint sum, hi, lo;
    @(negedge clk);
    iv = v; ifs = f; il = l; ia = a; iw = w;
    smp = cyc + 1;
    s = use_ovr ? ovr : dot(a, w);
    if (v) for (int d = 0; d < 3; d++) begin
      if (f) begin
        macc[d] = s;
        msat[d] = 0;
        mst[d] = !l;
        if (l) q[d].push_back('{s, 1'b0, smp + 5});
      end else if (mst[d]) begin
        hi = (longint'(1) << (wd[d] - 1)) - 1;
        lo = -hi - 1;
        sum = longint'(macc[d]) + longint'(s);
        if (sum > hi || sum < lo) begin
          msat[d] = 1;
          if (satv[d]) sum = (sum > hi) ? hi : lo;
          else sum = (sum > hi) ? sum - (longint'(1) << wd[d]) : sum + (longint'(1) << wd[d]);
        end
        macc[d] = int'(sum);
        if (l) begin
          mst[d] = 0;
          q[d].push_back('{macc[d], msat[d], smp + 5});
        end
      end
    end
  endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) beat(0, i[0], 1, 32'hFFFF_FFFF, 32'h7777_7777);
  endtask
  initial begin
    tbl[0] = '{32'hFFFF_FFFF, 32'h7777_7777, 840};
    tbl[1] = '{32'hFFFF_FFFF, 32'hFFFF_FFFF, -840};
    tbl[2] = '{32'hFFFF_FFFF, 32'h8888_8888, 0};
    tbl[3] = '{32'h1111_1111, 32'h1111_1111, 8};
    tbl[4] = '{32'h7654_3210, 32'h1234_5670, 84};
    tbl[5] = '{32'h7654_3210, 32'h9ABC_DEF0, -84};
    tbl[6] = '{32'hF0F0_F0F0, 32'h7F7F_7F7F, 420};
    #3;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("reset o_valid dut%0d", d), int'(ov[d]), 0);
      chk($sformatf("reset o_result dut%0d", d), res[d], 0);
      chk($sformatf("reset o_sat dut%0d", d), int'(os[d]), 0);
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 7; i++) beat(1, 1, 1, tbl[i].a, tbl[i].w, 1, tbl[i].r);
    idle(3);
    beat(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(2);
    beat(1, 0, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(2);
    beat(1, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    idle(2);
    for (int i = 0; i < 3; i++) beat(1, i == 0, i == 2, 32'hFFFF_FFFF, 32'h7777_7777);
    beat(1, 1, 1, 32'hFFFF_FFFF, 32'h7777_7777);
    idle(2);
    beat(1, 0, 1, 32'hFFFF_FFFF, 32'h7777_7777);
    beat(1, 0, 0, 32'hFFFF_FFFF, 32'h7777_7777);
    beat(1, 1, 0, 32'hFFFF_FFFF, 32'h7777_7777);
    beat(1, 0, 0, 32'hFFFF_FFFF, 32'h7777_7777);
    beat(1, 1, 0, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    beat(0, 1, 1, 32'hFFFF_FFFF, 32'h7777_7777);
    beat(1, 0, 1, tbl[4].a, tbl[4].w);
    idle(8);
    beat(1, 1, 0, 32'hFFFF_FFFF, 32'h7777_7777);
    idle(1);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 0;
    #1;
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("midreset o_valid dut%0d", d), int'(ov[d]), 0);
      chk($sformatf("midreset o_result dut%0d", d), res[d], 0);
      chk($sformatf("midreset o_sat dut%0d", d), int'(os[d]), 0);
      q[d].delete();
      mst[d] = 0;
      hold[d] = 0;
    end
    repeat (2) @(negedge clk);
    rst_n = 1;
    beat(1, 1, 0, tbl[4].a, tbl[4].w);
    beat(1, 0, 1, 32'hFFFF_FFFF, 32'h7777_7777);
    idle(10);
    for (int d = 0; d < 3; d++) chk($sformatf("missing o_valid dut%0d", d), q[d].size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
